ex_mul_pipe: RTL and testbench
==============================

EX_MUL_PIPE -- requirements
Module: ex_mul_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have parameter MUL_STAGES, default 5, pipeline depth; only the value 5 is supported.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the posedge.
REQ-004 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports EX_a, EX_b  in  XLEN  multiplicand and multiplier from the D-to-EX register.
REQ-006 SHALL have ports EX_mul  in  1  and  EX_rd  in  5  marking a multiply in EX and its destination register.
REQ-007 SHALL have port MEM_stall  in  1  global freeze.
REQ-008 SHALL have ports D_rs1, D_rs2  in  5  decode-stage source registers.
REQ-009 SHALL have port mul_hazard  out  1  RAW hazard request to the decode stall logic.
REQ-010 SHALL have ports M5_valid  out  1,  M5_rd  out  5,  M5_result  out  XLEN  writeback request.
REQ-011 SHALL have ports fwd_valid  out  1,  fwd_rd  out  5,  fwd_data  out  XLEN  forwarding source.

Function
REQ-012 SHALL hold five stage registers M1..M5; each holds valid, rd, and a data payload.
REQ-013 SHALL capture {EX_a, EX_b, EX_rd} into M1 with valid=1 when EX_mul=1, MEM_stall=0, and EX_rd!=0.
REQ-014 SHALL load M1 valid=0 when EX_mul=0 or EX_rd=0, in any cycle with MEM_stall=0.
REQ-015 SHALL advance every stage Mk to Mk+1 on each posedge with MEM_stall=0.
REQ-016 SHALL hold all stages unchanged, including M5 outputs, on each posedge with MEM_stall=1.
REQ-017 SHALL split the arithmetic as follows: M1 registers the partial products lo*lo, lo*hi, and hi*lo of the 16-bit halves; M2 sums the two cross terms; M3 forms lo*lo + (cross<<16); M4 and M5 pass the sum through.
REQ-018 SHALL make M5_result equal (EX_a*EX_b) mod 2^XLEN, unsigned; the low XLEN bits are identical for signed operands.
REQ-019 SHALL present a result at M5 exactly 5 unfrozen posedges after capture; throughput is one multiply per cycle.
REQ-020 SHALL drive M5_valid and M5_rd directly from the M5 stage register.
REQ-021 SHALL NOT let EX_taken influence the pipe; multiplies already in M1..M5 are older than the branch and complete.
REQ-022 SHALL assert mul_hazard combinationally when a valid stage in the checked set has rd equal to a nonzero D_rs1 or D_rs2.
REQ-023 SHALL treat the EX-stage multiply (EX_mul with EX_rd) as a member of the checked set.
REQ-024 SHALL treat register 0 as never hazardous.
REQ-025 SHALL use the result of the youngest matching stage when several stages share an rd; hazard is asserted regardless.

Reset
REQ-026 SHALL, when rst=1 at a posedge, clear every stage valid, rd, and payload to 0, overriding MEM_stall and EX_mul.
REQ-027 SHALL keep M5_valid=0, M5_rd=0, M5_result=0, mul_hazard=0 (for any D_rs), and fwd_*=0 after reset until new captures arrive.
REQ-028 SHALL discard any in-flight multiply when reset is asserted mid-operation; no stale writeback SHALL follow.

Configuration
REQ-029 SHALL define the macro MUL_BYPASS_EN to control forwarding.
REQ-030 With MUL_BYPASS_EN defined: fwd_valid=M5_valid, fwd_rd=M5_rd, fwd_data=M5_result, and the hazard checked set SHALL be EX and M1..M4.
REQ-031 Without MUL_BYPASS_EN: fwd_valid=0, fwd_rd=0, fwd_data=0, and the hazard checked set SHALL be EX and M1..M5.

Structure
REQ-032 SHALL take XLEN, the stage count, and the stage-record typedef (valid, rd, payload) from the shared pipeline package.
REQ-033 SHALL isolate the 16x16 partial-product logic in one sub-module, mul16_pp, instantiated three times in M1.

Verification
REQ-034 Reset check: rst for 2 cycles with EX_mul=1 -> all outputs 0 and mul_hazard=0 for D_rs1=5.
REQ-035 Basic latency: EX_a=0x0001_0003, EX_b=0x0002_0005, EX_rd=7 at cycle 0 -> M5_valid=1, M5_rd=7, M5_result=0x000B_000F at cycle 5.
REQ-036 Wrap-around: EX_a=0xFFFF_FFFF, EX_b=0xFFFF_FFFF -> M5_result=0x0000_0001; EX_a=0xFFFF_FFFF, EX_b=2 -> 0xFFFF_FFFE.
REQ-037 Back-to-back with freeze: issue three muls to rd 1,2,3; MEM_stall high for 3 cycles after the second -> results retire in order, latency 5+3, no loss or duplicates.
REQ-038 Hazard: mul to rd=9 in M2, D_rs2=9 -> mul_hazard=1; with the mul in M5, mul_hazard=1 without MUL_BYPASS_EN and 0 with it (fwd_valid=1, fwd_rd=9); D_rs1=0 with EX_rd=0 -> 0.
REQ-039 Mid-flight reset: rst asserted while M3 is valid -> M5_valid stays 0 for the following 6 cycles.

Source files
------------

// File: rtl/ex_mul_pipe_pkg.sv
// rtl/ex_mul_pipe_pkg.sv - shared pipeline constants, stage record and hazard helper
//
// Purpose : widths, stage count and the per-stage record (valid, rd, payload)
//           used by the multiply pipe, plus the register-match helper used by
//           the RAW hazard check.
// Contents: PIPE_XLEN, PIPE_STAGES, PIPE_HALF, stage_t, STAGE_EMPTY, rd_hazard()

package ex_mul_pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_STAGES = 5;
    localparam int PIPE_HALF   = PIPE_XLEN / 2;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rd;
        logic [PIPE_XLEN-1:0] data;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // A stage conflicts with decode when it is live and writes one of the
    // decode sources. x0 is never a real destination, so rd=0 never matches.
    function automatic logic rd_hazard(input logic       v,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return v && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/ex_mul_pipe_mul16.sv
// rtl/ex_mul_pipe_mul16.sv - 16x16 unsigned partial-product multiplier
//
// Purpose : one unsigned 16x16 -> 32 partial product for the first multiply stage.
// Ports   : a, b (16-bit operand halves), p (32-bit full product)

module mul16_pp (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = {16'd0, a} * {16'd0, b};

endmodule

// File: rtl/ex_mul_pipe.sv
// rtl/ex_mul_pipe.sv - five-stage pipelined 32-bit multiplier with RAW hazard detect
//
// Purpose : accepts a multiply from EX, retires (a*b) mod 2^XLEN at M5 five
//           unfrozen cycles later, one multiply per cycle, and flags decode
//           RAW hazards against in-flight destinations.
// Ports   : clk, rst (sync, active-high)
//           EX_a, EX_b, EX_mul, EX_rd   - multiply issued from EX
//           MEM_stall                   - global freeze
//           D_rs1, D_rs2, mul_hazard    - decode hazard check
//           M5_valid, M5_rd, M5_result  - writeback request
//           fwd_valid, fwd_rd, fwd_data - forwarding source
// Config  : MUL_BYPASS_EN - when defined, M5 is forwarded and excluded from
//           the hazard check; otherwise forwarding outputs are tied to 0.

module ex_mul_pipe
    import ex_mul_pipe_pkg::*;
#(
    parameter int XLEN       = PIPE_XLEN,
    parameter int MUL_STAGES = PIPE_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] EX_a,
    input  logic [XLEN-1:0] EX_b,
    input  logic            EX_mul,
    input  logic [4:0]      EX_rd,
    input  logic            MEM_stall,
    input  logic [4:0]      D_rs1,
    input  logic [4:0]      D_rs2,
    output logic            mul_hazard,
    output logic            M5_valid,
    output logic [4:0]      M5_rd,
    output logic [XLEN-1:0] M5_result,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    // M1 carries lo*lo in its record payload plus the two cross terms;
    // M2 carries lo*lo plus the summed cross term; M3..M5 carry the product.
    stage_t            m1_q, m1_d;
    logic [XLEN-1:0]   m1_lh_q, m1_lh_d;
    logic [XLEN-1:0]   m1_hl_q, m1_hl_d;
    stage_t            m2_q, m2_d;
    logic [XLEN-1:0]   m2_cross_q, m2_cross_d;
    stage_t            pass_q [3:MUL_STAGES];
    stage_t            pass_d [3:MUL_STAGES];

    logic [XLEN-1:0]   pp_ll, pp_lh, pp_hl;
    logic              capture;

    mul16_pp u_pp_ll (.a(EX_a[PIPE_HALF-1:0]),    .b(EX_b[PIPE_HALF-1:0]),    .p(pp_ll));
    mul16_pp u_pp_lh (.a(EX_a[PIPE_HALF-1:0]),    .b(EX_b[XLEN-1:PIPE_HALF]), .p(pp_lh));
    mul16_pp u_pp_hl (.a(EX_a[XLEN-1:PIPE_HALF]), .b(EX_b[PIPE_HALF-1:0]),    .p(pp_hl));

    // A multiply to x0 has no architectural effect, so it is never tracked.
    assign capture = EX_mul && (EX_rd != 5'd0);

    always_comb begin
        m1_d       = m1_q;
        m1_lh_d    = m1_lh_q;
        m1_hl_d    = m1_hl_q;
        m2_d       = m2_q;
        m2_cross_d = m2_cross_q;
        pass_d     = pass_q;
        if (!MEM_stall) begin
            m1_d    = STAGE_EMPTY;
            m1_lh_d = '0;
            m1_hl_d = '0;
            if (capture) begin
                m1_d.valid = 1'b1;
                m1_d.rd    = EX_rd;
                m1_d.data  = pp_ll;
                m1_lh_d    = pp_lh;
                m1_hl_d    = pp_hl;
            end
            m2_d       = m1_q;
            m2_cross_d = m1_lh_q + m1_hl_q;
            // hi*hi only affects bits >= 2^32, so it is never formed.
            pass_d[3]      = m2_q;
            pass_d[3].data = m2_q.data + (m2_cross_q << PIPE_HALF);
            for (int k = 4; k <= MUL_STAGES; k++) begin
                pass_d[k] = pass_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_q       <= STAGE_EMPTY;
            m1_lh_q    <= '0;
            m1_hl_q    <= '0;
            m2_q       <= STAGE_EMPTY;
            m2_cross_q <= '0;
            for (int k = 3; k <= MUL_STAGES; k++) begin
                pass_q[k] <= STAGE_EMPTY;
            end
        end else begin
            m1_q       <= m1_d;
            m1_lh_q    <= m1_lh_d;
            m1_hl_q    <= m1_hl_d;
            m2_q       <= m2_d;
            m2_cross_q <= m2_cross_d;
            pass_q     <= pass_d;
        end
    end

    assign M5_valid  = pass_q[MUL_STAGES].valid;
    assign M5_rd     = pass_q[MUL_STAGES].rd;
    assign M5_result = pass_q[MUL_STAGES].data;

`ifdef MUL_BYPASS_EN
    // M5 is served by the bypass, so only younger stages stall decode.
    localparam int HZ_LAST = MUL_STAGES - 1;
    assign fwd_valid = M5_valid;
    assign fwd_rd    = M5_rd;
    assign fwd_data  = M5_result;
`else
    localparam int HZ_LAST = MUL_STAGES;
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

    // The EX term is masked during reset: that multiply will not be captured,
    // so it cannot produce a result decode would need to wait for.
    always_comb begin
        mul_hazard = rd_hazard(EX_mul && !rst, EX_rd, D_rs1, D_rs2);
        mul_hazard = mul_hazard | rd_hazard(m1_q.valid, m1_q.rd, D_rs1, D_rs2);
        mul_hazard = mul_hazard | rd_hazard(m2_q.valid, m2_q.rd, D_rs1, D_rs2);
        for (int k = 3; k <= HZ_LAST; k++) begin
            mul_hazard = mul_hazard | rd_hazard(pass_q[k].valid, pass_q[k].rd, D_rs1, D_rs2);
        end
    end

endmodule

// File: tb/tb_ex_mul_pipe.sv
// tb/tb_ex_mul_pipe.sv - directed self-checking bench for ex_mul_pipe

module tb_ex_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_a, EX_b;
    logic        EX_mul;
    logic [4:0]  EX_rd;
    logic        MEM_stall;
    logic [4:0]  D_rs1, D_rs2;
    logic        mul_hazard;
    logic        M5_valid;
    logic [4:0]  M5_rd;
    logic [31:0] M5_result;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int vectors    = 0;
    int miscompares = 0;

    ex_mul_pipe #(.XLEN(32), .MUL_STAGES(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .EX_a       (EX_a),
        .EX_b       (EX_b),
        .EX_mul     (EX_mul),
        .EX_rd      (EX_rd),
        .MEM_stall  (MEM_stall),
        .D_rs1      (D_rs1),
        .D_rs2      (D_rs2),
        .mul_hazard (mul_hazard),
        .M5_valid   (M5_valid),
        .M5_rd      (M5_rd),
        .M5_result  (M5_result),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;

`ifdef MUL_BYPASS_EN
    localparam logic       BYP = 1'b1;
`else
    localparam logic       BYP = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        EX_a   = a;
        EX_b   = b;
        EX_rd  = rd;
        EX_mul = 1'b1;
    endtask

    logic        exp_v;
    logic [4:0]  frz_rd  [1:3];
    logic [31:0] frz_res [1:3];

    initial begin
        frz_rd[1] = 5'd1; frz_res[1] = 32'd12;
        frz_rd[2] = 5'd2; frz_res[2] = 32'd30;
        frz_rd[3] = 5'd3; frz_res[3] = 32'd56;

        // Reset held two cycles with a live multiply in EX
        rst = 1'b1; MEM_stall = 1'b0;
        issue(32'd3, 32'd5, 5'd5);
        D_rs1 = 5'd5; D_rs2 = 5'd0;
        tick(); tick();
        chk("rst_m5_valid",  M5_valid,   0);
        chk("rst_m5_rd",     M5_rd,      0);
        chk("rst_m5_result", M5_result,  0);
        chk("rst_hazard",    mul_hazard, 0);
        chk("rst_fwd_valid", fwd_valid,  0);
        chk("rst_fwd_rd",    fwd_rd,     0);
        chk("rst_fwd_data",  fwd_data,   0);
        rst = 1'b0; EX_mul = 1'b0;
        tick();
        chk("post_rst_hazard", mul_hazard, 0);
        chk("post_rst_valid",  M5_valid,   0);
        D_rs1 = 5'd0;

        // Basic latency: result appears after exactly five posedges
        issue(32'h0001_0003, 32'h0002_0005, 5'd7);
        tick();
        EX_mul = 1'b0;
        tick(); tick(); tick();
        chk("lat_early_valid", M5_valid, 0);
        tick();
        chk("lat_valid",  M5_valid,  1);
        chk("lat_rd",     M5_rd,     7);
        chk("lat_result", M5_result, 32'h000B_000F);
        tick();
        chk("lat_drain",  M5_valid,  0);

        // Wrap-around, issued back-to-back
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        tick();
        issue(32'hFFFF_FFFF, 32'd2, 5'd11);
        tick();
        EX_mul = 1'b0;
        tick(); tick(); tick();
        chk("wrap1_rd",     M5_rd,     10);
        chk("wrap1_result", M5_result, 32'h0000_0001);
        tick();
        chk("wrap2_valid",  M5_valid,  1);
        chk("wrap2_rd",     M5_rd,     11);
        chk("wrap2_result", M5_result, 32'hFFFF_FFFE);

        // Three multiplies with a 3-cycle freeze after the second
        issue(32'd3, 32'd4, 5'd1);
        tick();
        issue(32'd5, 32'd6, 5'd2);
        tick();
        issue(32'd7, 32'd8, 5'd3);
        MEM_stall = 1'b1;
        tick(); tick(); tick();
        MEM_stall = 1'b0;
        tick();
        EX_mul = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = (i >= 1) && (i <= 3);
            chk($sformatf("frz_valid_%0d", i), M5_valid, exp_v);
            if (exp_v) begin
                chk($sformatf("frz_rd_%0d", i),     M5_rd,     frz_rd[i]);
                chk($sformatf("frz_result_%0d", i), M5_result, frz_res[i]);
            end
        end

        // Hazard tracking through the pipe
        issue(32'd2, 32'd3, 5'd9);
        D_rs2 = 5'd9;
        tick();
        EX_mul = 1'b0;
        tick();
        chk("hz_m2", mul_hazard, 1);
        tick(); tick(); tick();
        chk("hz_m5_valid",  M5_valid,   1);
        chk("hz_m5_rd",     M5_rd,      9);
        chk("hz_m5_result", M5_result,  6);
        chk("hz_m5",        mul_hazard, !BYP);
        chk("hz_fwd_valid", fwd_valid,  BYP);
        chk("hz_fwd_rd",    fwd_rd,     BYP ? 32'd9 : 32'd0);
        chk("hz_fwd_data",  fwd_data,   BYP ? 32'd6 : 32'd0);
        MEM_stall = 1'b1;
        tick(); tick();
        chk("hold_valid",  M5_valid,  1);
        chk("hold_rd",     M5_rd,     9);
        chk("hold_result", M5_result, 6);
        D_rs2 = 5'd0; D_rs1 = 5'd0;
        issue(32'd4, 32'd4, 5'd0);
        #1;
        chk("hz_x0", mul_hazard, 0);
        MEM_stall = 1'b0;
        tick();
        EX_mul = 1'b0;
        tick(); tick(); tick(); tick();
        chk("x0_no_writeback", M5_valid, 0);

        // Reset with a multiply in M3: nothing may retire afterwards
        issue(32'd9, 32'd9, 5'd4);
        tick();
        EX_mul = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        D_rs1 = 5'd4;
        #1;
        chk("mid_rst_hazard", mul_hazard, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mid_rst_valid_%0d", i), M5_valid, 0);
            tick();
        end
        chk("mid_rst_result", M5_result, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
